// File: rtl/dcache_defs.sv
// dcache_defs: shared geometry and FSM state encodings for the direct-mapped data cache
package dcache_defs;
  localparam int LINES = 64;
  localparam int WORDS = 4;
  localparam int TAGW = 22;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage, async read at idx/roff, sync write of one word and of line metadata
// ports: clk, rst (clears valid only); idx/roff read -> rdata, rtag, rvalid; dwe/woff/wdata word write; mwe/mvalid/mtag metadata write
module dcache_array #(
  parameter int LINES = dcache_defs::LINES,
  parameter int WORDS = dcache_defs::WORDS,
  parameter int TAGW = dcache_defs::TAGW,
  localparam int IW = $clog2(LINES),
  localparam int OW = $clog2(WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   idx,
  input  logic [OW-1:0]   roff,
  output logic [31:0]     rdata,
  output logic [TAGW-1:0] rtag,
  output logic            rvalid,
  input  logic            dwe,
  input  logic [OW-1:0]   woff,
  input  logic [31:0]     wdata,
  input  logic            mwe,
  input  logic            mvalid,
  input  logic [TAGW-1:0] mtag
);
  logic [31:0] data [LINES*WORDS];
  logic [TAGW-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  assign rdata = data[{idx, roff}];
  assign rtag = tags[idx];
  assign rvalid = valid[idx];
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (mwe) valid[idx] <= mvalid;
  end
  always_ff @(posedge clk) begin
    if (mwe && mvalid) tags[idx] <= mtag;
    if (dwe) data[{idx, woff}] <= wdata;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through, no-write-allocate data cache controller for the memory stage
// ports: clk, rst; MemReadM/MemWriteM/ALUoutM/WriteDataM from the pipeline -> ReadDataM, Mem_Stall;
// MemReq/MemWE/MemAddr/MemWData to main memory, MemRData/MemReady back
module dcache_ctrl import dcache_defs::*; #(
  parameter int LINES = dcache_defs::LINES,
  parameter int WORDS = dcache_defs::WORDS,
  parameter int TAGW = dcache_defs::TAGW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        Mem_Stall,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady
);
  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  state_t state, nstate;
  logic [OW-1:0] cnt, off, woff;
  logic [IW-1:0] idx;
  logic [TAGW-1:0] atag, rtag;
  logic [31:0] wdat;
  logic rvalid, hit, last, dwe, mwe, mvalid;
  logic unused_ok;
  assign unused_ok = ^ALUoutM[1:0];
  assign off = ALUoutM[OW+1:2];
  assign idx = ALUoutM[IW+OW+1:OW+2];
  assign atag = ALUoutM[31 -: TAGW];
  assign hit = rvalid && rtag == atag;
  assign last = cnt == OW'(WORDS-1);
  dcache_array #(.LINES(LINES), .WORDS(WORDS), .TAGW(TAGW)) u_array (
    .clk(clk), .rst(rst), .idx(idx), .roff(off), .rdata(ReadDataM), .rtag(rtag), .rvalid(rvalid),
    .dwe(dwe), .woff(woff), .wdata(wdat), .mwe(mwe), .mvalid(mvalid), .mtag(atag)
  );
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nstate;
    cnt <= (rst || state != REFILL) ? '0 : (MemReady ? cnt + 1'b1 : cnt);
  end
  always_comb begin
    nstate = state;
    Mem_Stall = 1'b0;
    MemReq = 1'b0;
    MemWE = 1'b0;
    MemAddr = ALUoutM;
    MemWData = WriteDataM;
    dwe = 1'b0;
    woff = off;
    wdat = WriteDataM;
    mwe = 1'b0;
    mvalid = 1'b0;
    case (state)
      IDLE: begin
        Mem_Stall = MemWriteM || (MemReadM && !hit);
        nstate = MemWriteM ? WRITE : (MemReadM && !hit) ? REFILL : IDLE;
      end
      REFILL: begin
        MemReq = 1'b1;
        Mem_Stall = 1'b1;
        MemAddr = {atag, idx, cnt, 2'b00};
        dwe = MemReady;
        woff = cnt;
        wdat = MemRData;
        // valid stays low for the whole refill so a half-filled line never hits
        mwe = 1'b1;
        mvalid = MemReady && last;
        nstate = (MemReady && last) ? IDLE : REFILL;
      end
      WRITE: begin
        MemReq = 1'b1;
        MemWE = 1'b1;
        Mem_Stall = !MemReady;
        dwe = MemReady && hit;
        nstate = MemReady ? IDLE : WRITE;
      end
      default: nstate = IDLE;
    endcase
    if (rst) begin
      nstate = IDLE;
      Mem_Stall = 1'b0;
      MemReq = 1'b0;
      MemWE = 1'b0;
      dwe = 1'b0;
      mwe = 1'b0;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scenario bench for dcache_ctrl with a pattern memory and a memory-transaction scoreboard
module tb_dcache_ctrl;
  logic clk = 0, rst = 1, MemReadM = 0, MemWriteM = 0;
  logic [31:0] ALUoutM = 0, WriteDataM = 0;
  logic [31:0] ReadDataM, MemAddr, MemWData, MemRData;
  logic Mem_Stall, MemReq, MemWE, MemReady;
  int total = 0, bad = 0, dly = 0, wcnt = 0;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t tq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a[31:4] == 28'h4) ? 32'hA0 + 32'(a[3:2]) : {a[15:0], 16'hC0DE};
  endfunction

  assign MemRData = memval(MemAddr);
  assign MemReady = MemReq && (wcnt >= dly);
  always @(posedge clk) wcnt <= (MemReq && !MemReady) ? wcnt + 1 : 0;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALUoutM(ALUoutM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .Mem_Stall(Mem_Stall), .MemReq(MemReq),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady)
  );

  task automatic run_op(input string name, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic miss, input logic [31:0] expd);
    int n, exp_n;
    logic done;
    txn_t t;
    ALUoutM = a; WriteDataM = wd; MemReadM = rd; MemWriteM = wr; dly = d;
    if (wr) tq.push_back('{1'b1, a, wd});
    else if (miss) for (int i = 0; i < 4; i++) tq.push_back('{1'b0, {a[31:4], 2'(i), 2'b00}, 32'h0});
    exp_n = wr ? 1 + d : (miss ? 5 : 0);
    n = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (MemReq && MemWE) begin
        total++;
        if (MemAddr !== a || MemWData !== wd) begin
          bad++; $display("FAIL %s held write addr=%h data=%h want %h/%h", name, MemAddr, MemWData, a, wd);
        end
      end
      if (MemReq && MemReady) begin
        total++;
        if (tq.size() == 0) begin
          bad++; $display("FAIL %s unexpected txn we=%b addr=%h", name, MemWE, MemAddr);
        end else begin
          t = tq.pop_front();
          if (MemWE !== t.we || MemAddr !== t.addr || (t.we && MemWData !== t.data)) begin
            bad++; $display("FAIL %s txn we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                            name, MemWE, MemAddr, MemWData, t.we, t.addr, t.data);
          end
        end
      end
      if (!Mem_Stall) done = 1; else n++;
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s timeout stall never dropped", name); end
    total++;
    if (n !== exp_n) begin bad++; $display("FAIL %s stall cycles got=%0d want=%0d", name, n, exp_n); end
    if (rd && !wr) begin
      total++;
      if (ReadDataM !== expd) begin bad++; $display("FAIL %s rdata got=%h want=%h", name, ReadDataM, expd); end
    end
    if (rd && !wr && !miss) begin
      total++;
      if (MemReq !== 1'b0) begin bad++; $display("FAIL %s hit MemReq got=%b want=0", name, MemReq); end
    end
    total++;
    if (tq.size() != 0) begin bad++; $display("FAIL %s missing txns left=%0d want=0", name, tq.size()); end
    tq.delete();
    @(posedge clk); #1;
    MemReadM = 0; MemWriteM = 0;
  endtask

  task automatic test_reset();
    rst = 1; MemReadM = 1; ALUoutM = 32'h40;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({MemReq, MemWE, Mem_Stall} !== 3'b000) begin
        bad++; $display("FAIL reset outputs req/we/stall=%b want=000", {MemReq, MemWE, Mem_Stall});
      end
    end
    @(posedge clk); #1;
    rst = 0; MemReadM = 0;
  endtask

  task automatic test_refill();
    run_op("refill40", 1, 0, 32'h40, 0, 0, 1, 32'hA0);
  endtask

  task automatic test_hit();
    run_op("hit48", 1, 0, 32'h48, 0, 0, 0, 32'hA2);
  endtask

  task automatic test_store_hit();
    run_op("store44", 0, 1, 32'h44, 32'hDEADBEEF, 3, 0, 0);
    run_op("load44", 1, 0, 32'h44, 0, 0, 0, 32'hDEADBEEF);
  endtask

  task automatic test_both_high();
    run_op("both4c", 1, 1, 32'h4C, 32'h12345678, 0, 0, 0);
    run_op("load4c", 1, 0, 32'h4C, 0, 0, 0, 32'h12345678);
  endtask

  task automatic test_conflict();
    run_op("refill440", 1, 0, 32'h440, 0, 0, 1, memval(32'h440));
    run_op("hit444", 1, 0, 32'h444, 0, 0, 0, memval(32'h444));
    run_op("remiss40", 1, 0, 32'h40, 0, 0, 1, 32'hA0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_op("b2b", 1, 0, 32'h40 + 32'(4 * i), 0, 0, 0, 32'hA0 + 32'(i));
  endtask

  task automatic test_rst_refill();
    int n;
    MemReadM = 1; ALUoutM = 32'h80; dly = 0; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (MemReq && MemReady) n++;
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL rstrefill words got=%0d want=2", n); end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    total++;
    if ({MemReq, MemWE, Mem_Stall} !== 3'b000) begin
      bad++; $display("FAIL rstrefill outputs req/we/stall=%b want=000", {MemReq, MemWE, Mem_Stall});
    end
    @(posedge clk); #1;
    rst = 0; MemReadM = 0;
    @(negedge clk);
    total++;
    if (MemReq !== 1'b0) begin bad++; $display("FAIL rstrefill idle MemReq got=%b want=0", MemReq); end
    @(posedge clk); #1;
    run_op("refill80", 1, 0, 32'h80, 0, 0, 1, memval(32'h80));
  endtask

  task automatic test_store_miss();
    run_op("store100", 0, 1, 32'h100, 32'h55, 0, 0, 0);
    run_op("miss100", 1, 0, 32'h100, 0, 0, 1, memval(32'h100));
  endtask

  initial begin
    test_reset();
    test_refill();
    test_hit();
    test_store_hit();
    test_both_high();
    test_conflict();
    test_back_to_back();
    test_rst_refill();
    test_store_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameters SHALL be: LINES, 64, number of direct-mapped lines; WORDS, 4, 32-bit words per line; TAGW, 22, tag width (32 - log2(LINES) - log2(WORDS) - 2).
REQ-003 Ports, in order, SHALL be:
 clk  in  1  pipeline clock
 rst  in  1  synchronous active-high reset
 MemReadM  in  1  memory-stage load
 MemWriteM  in  1  memory-stage store
 ALUoutM  in  32  byte address; word-aligned
 WriteDataM  in  32  store data
 ReadDataM  out  32  load data to memory stage (Mem_RDM)
 Mem_Stall  out  1  freezes pipeline, including the M-to-W register
 MemReq  out  1  main-memory request valid
 MemWE  out  1  main-memory write (1) / read (0)
 MemAddr  out  32  main-memory word address
 MemWData  out  32  main-memory write data
 MemRData  in  32  main-memory read data
 MemReady  in  1  main-memory completes current request this cycle

Function
REQ-004 Address split SHALL be offset ALUoutM[3:2], index ALUoutM[9:4], tag ALUoutM[31:10] (default parameters).
REQ-005 Hit SHALL be valid[index] && tag[index] == address tag; evaluated combinationally.
REQ-006 States SHALL be IDLE, REFILL, WRITE.
REQ-007 IDLE: load hit -> Mem_Stall=0, ReadDataM = array word, stay IDLE; load miss -> Mem_Stall=1, cnt<=0, go REFILL; store -> Mem_Stall=1, go WRITE; neither -> Mem_Stall=0.
REQ-008 MemReadM and MemWriteM both high SHALL be treated as a store.
REQ-009 REFILL: MemReq=1, MemWE=0, MemAddr={tag,index,cnt,2'b00}, Mem_Stall=1; on MemReady write MemRData into array word cnt and increment cnt (2-bit, wraps).
REQ-010 REFILL with MemReady and cnt==WORDS-1 SHALL set valid[index]=1, tag[index]=address tag, and go IDLE; the retried load then hits with zero further stall.
REQ-011 valid[index] SHALL be cleared on the first REFILL cycle so a partially filled line never hits.
REQ-012 WRITE (write-through, no-write-allocate): MemReq=1, MemWE=1, MemAddr=ALUoutM, MemWData=WriteDataM; Mem_Stall=!MemReady.
REQ-013 WRITE with MemReady SHALL update the array word if hit, leave tags/valid unchanged on miss, and go IDLE.
REQ-014 MemReq SHALL be 0 in IDLE; MemAddr, MemWData SHALL be held stable while MemReq=1 and MemReady=0.
REQ-015 Latency with MemReady tied high: load hit 0 stall cycles, load miss 5, store 1.
REQ-016 ReadDataM SHALL be the combinational array word at index/offset whenever not in reset; its value is don't-care on miss.

Reset
REQ-017 rst SHALL clear all valid bits, force IDLE, cnt=0; outputs MemReq=0, MemWE=0, Mem_Stall=0 while rst=1.
REQ-018 rst during REFILL or WRITE SHALL abandon the transfer; the line under refill SHALL remain invalid.
REQ-019 Data and tag arrays SHALL NOT be reset.

Structure
REQ-020 LINES, WORDS, TAGW and state encodings SHALL live in a shared defines include file, dcache_defs.
REQ-021 Tag/valid/data storage SHALL be one sub-module, dcache_array (async read, sync write), instantiated by dcache_ctrl.

Verification
REQ-022 Reset then load 0x0000_0040, MemReady=1, MemRData=0xA0..0xA3 -> Mem_Stall high 5 cycles, MemAddr 0x40,0x44,0x48,0x4C, then ReadDataM=0xA0.
REQ-023 Load 0x0000_0048 after REQ-022 -> Mem_Stall=0, ReadDataM=0xA2, MemReq=0.
REQ-024 Store 0xDEAD_BEEF to 0x0000_0044 with MemReady delayed 3 cycles -> MemWE=1, MemAddr=0x44 held, Mem_Stall 4 cycles; next load 0x44 hits, returns 0xDEAD_BEEF.
REQ-025 Load 0x0000_0440 (same index, new tag) -> refill; then load 0x40 misses again.
REQ-026 rst asserted after second refill word of 0x0000_0080 -> IDLE, MemReq=0; subsequent load 0x80 misses and refills all 4 words.
REQ-027 Store to 0x0000_0100 (miss) -> one memory write, no refill; load 0x100 misses.
